wave_capture: RTL

WAVE_CAPTURE -- requirements
Module: wave_capture

---
 rtl/wave_capture_pkg.sv | 20 ++
 rtl/wave_capture_if.sv | 44 ++++
 rtl/wave_capture.sv | 107 ++++++++++
 3 files changed

// File: rtl/wave_capture_pkg.sv
// Shared definitions for the capture / display pair.
// Holds the capture FSM encoding, the capture length and the sample-RAM address width
// so that wave_capture and wave_display agree on buffer geometry.
package wave_capture_pkg;

   // One capture fills one half of the double-buffered sample RAM.
   localparam int unsigned CAPTURE_LEN = 256;
   localparam int unsigned IDX_W       = $clog2(CAPTURE_LEN);
   // {half, index}: one extra bit selects the RAM half.
   localparam int unsigned RAM_ADDR_W  = IDX_W + 1;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CAPTURE_LEN - 1);

   typedef enum logic [1:0] {
      StArmed  = 2'd0,
      StActive = 2'd1,
      StWait   = 2'd2
   } cap_state_e;

endpackage

// File: rtl/wave_capture_if.sv
// Sample-stream / sample-RAM bundle between the audio source, wave_capture and the RAM.
//   new_sample_ready  : one-cycle strobe, new_sample_in valid
//   new_sample_in     : two's-complement audio sample, SAMPLE_W bits
//   wave_display_idle : display is outside its active drawing region
//   write_address     : RAM write address {half, index}
//   write_enable      : RAM write strobe
//   write_sample      : unsigned (offset-binary) 8-bit sample
//   read_index        : RAM half owned by the display
// master: the capture block (drives the RAM side); slave: the surrounding system.
interface wave_capture_if
   import wave_capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 16
);

   logic                  new_sample_ready;
   logic [SAMPLE_W-1:0]   new_sample_in;
   logic                  wave_display_idle;
   logic [RAM_ADDR_W-1:0] write_address;
   logic                  write_enable;
   logic [7:0]            write_sample;
   logic                  read_index;

   modport master (
      input  new_sample_ready,
      input  new_sample_in,
      input  wave_display_idle,
      output write_address,
      output write_enable,
      output write_sample,
      output read_index
   );

   modport slave (
      output new_sample_ready,
      output new_sample_in,
      output wave_display_idle,
      input  write_address,
      input  write_enable,
      input  write_sample,
      input  read_index
   );

endinterface

// File: rtl/wave_capture.sv
// Rising-zero-crossing triggered audio capture into a double-buffered sample RAM.
// After a negative-to-non-negative crossing, CAPTURE_LEN consecutive samples are written
// into the half not owned by the display; the block then waits for the display to go idle,
// swaps halves and re-arms.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous active-high reset
//   cap_if : wave_capture_if.master (sample stream in, RAM write port and read_index out)
module wave_capture
   import wave_capture_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 16
) (
   input logic           clk,
   input logic           reset,
   wave_capture_if.master cap_if
);

   // Top 8 bits with the sign inverted: two's complement -> offset binary.
   function automatic logic [7:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
      return {~s[SAMPLE_W-1], s[SAMPLE_W-2 -: 7]};
   endfunction

   cap_state_e            state_q, state_d;
   logic [IDX_W-1:0]      count_q, count_d;
   logic                  prev_sign_q, prev_sign_d;
   logic                  read_index_q, read_index_d;
   logic                  we_q, we_d;
   logic [RAM_ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]            wsample_q, wsample_d;

   logic sample_sign;
   logic trigger;

   assign sample_sign = cap_if.new_sample_in[SAMPLE_W-1];
   assign trigger     = cap_if.new_sample_ready & prev_sign_q & ~sample_sign;

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      read_index_d = read_index_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wsample_d    = wsample_q;
      // Sign history tracks every accepted sample regardless of state.
      prev_sign_d  = cap_if.new_sample_ready ? sample_sign : prev_sign_q;

      unique case (state_q)
         StArmed: begin
            if (trigger) begin
               we_d      = 1'b1;
               waddr_d   = {~read_index_q, {IDX_W{1'b0}}};
               wsample_d = to_offset_binary(cap_if.new_sample_in);
               count_d   = IDX_W'(1);
               state_d   = StActive;
            end
         end
         StActive: begin
            if (cap_if.new_sample_ready) begin
               we_d      = 1'b1;
               waddr_d   = {~read_index_q, count_q};
               wsample_d = to_offset_binary(cap_if.new_sample_in);
               count_d   = count_q + IDX_W'(1);
               if (count_q == LastIdx) begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            // Hand the fresh half to the display only while it is not drawing.
            if (cap_if.wave_display_idle) begin
               read_index_d = ~read_index_q;
               state_d      = StArmed;
            end
         end
         default: begin
            state_d = StArmed;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StArmed;
         count_q      <= '0;
         prev_sign_q  <= 1'b0;
         read_index_q <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wsample_q    <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         prev_sign_q  <= prev_sign_d;
         read_index_q <= read_index_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wsample_q    <= wsample_d;
      end
   end

   assign cap_if.write_enable  = we_q;
   assign cap_if.write_address = waddr_q;
   assign cap_if.write_sample  = wsample_q;
   assign cap_if.read_index    = read_index_q;

endmodule
